// File: rtl/parking_lot_tracker.sv
// Multi-gate parking lot occupancy tracker.
// Each gate has an outer/inner beam pair, a 2-flop synchronizer and a
// direction FSM. Completed entries/exits from all gates are netted in one
// cycle and folded into a saturating occupancy count with sticky error flags.
module parking_lot_tracker #(
  parameter  int CAPACITY = 16,
  parameter  int GATES    = 2,
  localparam int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [GATES-1:0] outer,
  input  logic [GATES-1:0] inner,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [GATES-1:0] enter_pulse,
  output logic [GATES-1:0] exit_pulse,
  output logic             ovf,
  output logic             unf,
  output logic             seq_err
);

  localparam int SW = CNT_W + 4;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  typedef enum logic [2:0] {
    S_IDLE, S_IN1, S_IN2, S_IN3, S_OUT1, S_OUT2, S_OUT3, S_BAD
  } state_t;

  // Direction FSM transition for one gate; p = {outer, inner}.
  function automatic state_t fsm_next(input state_t s, input logic [1:0] p);
    state_t n;
    n = s;
    case (s)
      S_IDLE: case (p) 2'b10: n = S_IN1;  2'b01: n = S_OUT1; 2'b11: n = S_BAD;  default: n = s; endcase
      S_IN1:  case (p) 2'b11: n = S_IN2;  2'b00: n = S_IDLE; 2'b01: n = S_BAD;  default: n = s; endcase
      S_IN2:  case (p) 2'b01: n = S_IN3;  2'b10: n = S_IN1;  2'b00: n = S_BAD;  default: n = s; endcase
      S_IN3:  case (p) 2'b00: n = S_IDLE; 2'b11: n = S_IN2;  2'b10: n = S_BAD;  default: n = s; endcase
      S_OUT1: case (p) 2'b11: n = S_OUT2; 2'b00: n = S_IDLE; 2'b10: n = S_BAD;  default: n = s; endcase
      S_OUT2: case (p) 2'b10: n = S_OUT3; 2'b01: n = S_OUT1; 2'b00: n = S_BAD;  default: n = s; endcase
      S_OUT3: case (p) 2'b00: n = S_IDLE; 2'b11: n = S_OUT2; 2'b01: n = S_BAD;  default: n = s; endcase
      default: n = (p == 2'b00) ? S_IDLE : S_BAD;
    endcase
    return n;
  endfunction

  // Clamp the netted candidate into [0, CAPACITY]; returns {ovf, unf, value}.
  function automatic logic [CNT_W+1:0] saturate(input logic signed [SW-1:0] cand);
    if (cand > CAP_S)
      return {1'b1, 1'b0, CNT_W'(CAPACITY)};
    else if (cand[SW-1])
      return {1'b0, 1'b1, {CNT_W{1'b0}}};
    else
      return {2'b00, cand[CNT_W-1:0]};
  endfunction

  logic [GATES-1:0]      r_outer_m, r_outer_s, r_inner_m, r_inner_s;
  state_t                r_state [GATES];
  logic [GATES-1:0]      r_enter, r_exit;
  logic [CNT_W-1:0]      r_count;
  logic                  r_full, r_empty, r_ovf, r_unf, r_seq_err;

  state_t                w_next [GATES];
  logic [GATES-1:0]      w_ent, w_ext, w_err;
  logic [3:0]            w_e, w_x;
  logic signed [SW-1:0]  w_cand;
  logic [CNT_W+1:0]      w_sat;
  logic [CNT_W-1:0]      w_cnt_nxt;

  // Two-flop synchronizers for every raw beam input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outer_m <= '0;
      r_outer_s <= '0;
      r_inner_m <= '0;
      r_inner_s <= '0;
    end else begin
      r_outer_m <= outer;
      r_outer_s <= r_outer_m;
      r_inner_m <= inner;
      r_inner_s <= r_inner_m;
    end
  end

  // Next state, per-gate events and the netted, clamped occupancy.
  always_comb begin
    w_ent = '0;
    w_ext = '0;
    w_err = '0;
    w_e   = '0;
    w_x   = '0;
    for (int g = 0; g < GATES; g++) begin
      w_next[g] = fsm_next(r_state[g], {r_outer_s[g], r_inner_s[g]});
      w_ent[g]  = (r_state[g] == S_IN3)  && (w_next[g] == S_IDLE);
      w_ext[g]  = (r_state[g] == S_OUT3) && (w_next[g] == S_IDLE);
      w_err[g]  = (w_next[g] == S_BAD)   && (r_state[g] != S_BAD);
      w_e       = w_e + {3'b000, w_ent[g]};
      w_x       = w_x + {3'b000, w_ext[g]};
    end
    w_cand    = $signed({4'b0000, r_count})
              + $signed({{CNT_W{1'b0}}, w_e})
              - $signed({{CNT_W{1'b0}}, w_x});
    w_sat     = saturate(w_cand);
    w_cnt_nxt = w_sat[CNT_W-1:0];
  end

  // Gate FSM state and registered entry/exit pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int g = 0; g < GATES; g++) r_state[g] <= S_IDLE;
      r_enter <= '0;
      r_exit  <= '0;
    end else begin
      for (int g = 0; g < GATES; g++) r_state[g] <= w_next[g];
      r_enter <= w_ent;
      r_exit  <= w_ext;
    end
  end

  // Occupancy with full/empty derived from the same next value, plus sticky flags (set beats clear).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_count   <= w_cnt_nxt;
      r_full    <= (w_cnt_nxt == CNT_W'(CAPACITY));
      r_empty   <= (w_cnt_nxt == '0);
      r_ovf     <= w_sat[CNT_W+1] | (r_ovf & ~clr_flags);
      r_unf     <= w_sat[CNT_W]   | (r_unf & ~clr_flags);
      r_seq_err <= (|w_err)       | (r_seq_err & ~clr_flags);
    end
  end

  assign count       = r_count;
  assign full        = r_full;
  assign empty       = r_empty;
  assign enter_pulse = r_enter;
  assign exit_pulse  = r_exit;
  assign ovf         = r_ovf;
  assign unf         = r_unf;
  assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_parking_lot_tracker.sv
// Testbench for parking_lot_tracker: directed gate sequences followed by
// randomized multi-gate traffic checked against an arithmetic occupancy model.
module tb_parking_lot_tracker;

  localparam int CAPACITY = 16;
  localparam int GATES    = 2;
  localparam int CW       = $clog2(CAPACITY + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [GATES-1:0] outer, inner;
  logic             clr_flags;
  logic [CW-1:0]    count;
  logic             full, empty, ovf, unf, seq_err;
  logic [GATES-1:0] enter_pulse, exit_pulse;

  int checks = 0;
  int errors = 0;
  int ent_cnt [GATES];
  int ext_cnt [GATES];

  // model state for the randomized phase
  int m_cnt, m_e, m_x, cand, act, hold;
  logic m_ovf, m_unf;
  logic [3:0] ov [GATES];
  logic [3:0] iv [GATES];
  int exp_ent [GATES];
  int exp_ext [GATES];

  localparam logic [3:0] ENT_O = 4'b1100, ENT_I = 4'b0110;
  localparam logic [3:0] EXT_O = 4'b0110, EXT_I = 4'b1100;
  localparam logic [3:0] ABT_O = 4'b1110, ABT_I = 4'b0100;

  parking_lot_tracker #(.CAPACITY(CAPACITY), .GATES(GATES)) dut (
    .clk(clk), .reset(reset), .outer(outer), .inner(inner),
    .clr_flags(clr_flags), .count(count), .full(full), .empty(empty),
    .enter_pulse(enter_pulse), .exit_pulse(exit_pulse),
    .ovf(ovf), .unf(unf), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int g = 0; g < GATES; g++) begin
      ent_cnt[g] += int'(enter_pulse[g]);
      ext_cnt[g] += int'(exit_pulse[g]);
    end
  endtask

  task automatic zero_cnt();
    for (int g = 0; g < GATES; g++) begin
      ent_cnt[g] = 0;
      ext_cnt[g] = 0;
    end
  endtask

  // one full sensor sequence on a single gate; last step (00) held long enough to settle
  task automatic pass(input int g, input logic [3:0] o, input logic [3:0] i);
    for (int k = 3; k >= 0; k--) begin
      outer[g] = o[k];
      inner[g] = i[k];
      repeat (k == 0 ? 4 : 2) tick();
    end
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; outer = '0; inner = '0; clr_flags = 1'b0;
    zero_cnt();
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_pulses", {enter_pulse, exit_pulse}, 0);
    chk("rst_flags", {ovf, unf, seq_err}, 0);
    reset = 1'b1;
    tick();

    // 1: single entry on gate 0, exact latency and pulse width
    outer[0] = 1; inner[0] = 0; repeat (2) tick();
    outer[0] = 1; inner[0] = 1; repeat (2) tick();
    outer[0] = 0; inner[0] = 1; repeat (2) tick();
    zero_cnt();
    outer[0] = 0; inner[0] = 0;
    tick();
    chk("t1_edge_k_cnt", count, 0);
    tick();
    chk("t1_edge_k1_cnt", count, 0);
    chk("t1_edge_k1_pulse", enter_pulse, 0);
    tick();
    chk("t1_edge_k2_pulse", enter_pulse, 2'b01);
    chk("t1_edge_k2_cnt", count, 1);
    chk("t1_empty", empty, 0);
    tick();
    chk("t1_pulse_width", enter_pulse, 0);
    chk("t1_pulse_total", ent_cnt[0], 1);

    // 2: abort on gate 1
    zero_cnt();
    pass(1, ABT_O, ABT_I);
    chk("t2_no_pulse", ent_cnt[1] + ext_cnt[1], 0);
    chk("t2_count", count, 1);
    chk("t2_seq_err", seq_err, 0);

    // 3: fill to capacity, then one refused entry
    for (int n = 0; n < CAPACITY - 1; n++) pass(n % 2, ENT_O, ENT_I);
    chk("t3_count_cap", count, CAPACITY);
    chk("t3_full", full, 1);
    chk("t3_no_ovf", ovf, 0);
    zero_cnt();
    pass(1, ENT_O, ENT_I);
    chk("t3_refused_pulse", ent_cnt[1], 1);
    chk("t3_count_sat", count, CAPACITY);
    chk("t3_ovf", ovf, 1);
    pulse_clr();
    tick();
    chk("t3_ovf_clr", ovf, 0);

    // 4: exit at zero
    do_reset();
    zero_cnt();
    pass(0, EXT_O, EXT_I);
    chk("t4_exit_pulse", ext_cnt[0], 1);
    chk("t4_count", count, 0);
    chk("t4_unf", unf, 1);
    chk("t4_empty", empty, 1);

    // 5: simultaneous entry (gate 0) and exit (gate 1) at count 5
    do_reset();
    for (int n = 0; n < 5; n++) pass(0, ENT_O, ENT_I);
    chk("t5_pre_count", count, 5);
    outer = 2'b01; inner = 2'b10; repeat (2) tick();
    outer = 2'b11; inner = 2'b11; repeat (2) tick();
    outer = 2'b10; inner = 2'b01; repeat (2) tick();
    outer = 2'b00; inner = 2'b00; repeat (3) tick();
    chk("t5_enter_pulse", enter_pulse, 2'b01);
    chk("t5_exit_pulse", exit_pulse, 2'b10);
    repeat (2) tick();
    chk("t5_count", count, 5);
    chk("t5_flags", {ovf, unf, seq_err}, 0);

    // 6: illegal jump 00 -> 11 on gate 0, BAD held until 00
    zero_cnt();
    outer[0] = 1; inner[0] = 1; repeat (3) tick();
    chk("t6_seq_err", seq_err, 1);
    outer[0] = 0; inner[0] = 1; repeat (3) tick();
    outer[0] = 0; inner[0] = 0; repeat (4) tick();
    chk("t6_no_pulse", ent_cnt[0] + ext_cnt[0], 0);
    chk("t6_count", count, 5);
    pulse_clr();
    tick();
    chk("t6_seq_clr", seq_err, 0);
    pass(0, ENT_O, ENT_I);
    chk("t6_recover_count", count, 6);

    // 6b: async reset while gate 1 sits in IN2
    outer[1] = 1; inner[1] = 0; repeat (2) tick();
    outer[1] = 1; inner[1] = 1; repeat (3) tick();
    reset = 1'b0;
    #2;
    chk("t6_async_count", count, 0);
    chk("t6_async_empty", empty, 1);
    chk("t6_async_full", full, 0);
    chk("t6_async_pulses", {enter_pulse, exit_pulse}, 0);
    chk("t6_async_flags", {ovf, unf, seq_err}, 0);
    #2;
    reset = 1'b1;
    zero_cnt();
    repeat (4) tick();
    chk("t6_stuck_car_err", seq_err, 1);
    outer[1] = 0; inner[1] = 1; repeat (3) tick();
    outer[1] = 0; inner[1] = 0; repeat (4) tick();
    chk("t6_stuck_count", count, 0);
    chk("t6_stuck_pulses", ent_cnt[1] + ext_cnt[1], 0);

    // randomized lockstep traffic against the occupancy model
    do_reset();
    m_cnt = 0; m_ovf = 0; m_unf = 0;
    for (int t = 0; t < 60; t++) begin
      m_e = 0; m_x = 0;
      for (int g = 0; g < GATES; g++) begin
        act = int'($urandom_range(0, 9));
        exp_ent[g] = 0; exp_ext[g] = 0;
        if (act <= 4)      begin ov[g] = ENT_O; iv[g] = ENT_I; exp_ent[g] = 1; m_e++; end
        else if (act <= 7) begin ov[g] = EXT_O; iv[g] = EXT_I; exp_ext[g] = 1; m_x++; end
        else if (act == 8) begin ov[g] = ABT_O; iv[g] = ABT_I; end
        else               begin ov[g] = 4'b0000; iv[g] = 4'b0000; end
      end
      hold = int'($urandom_range(1, 3));
      zero_cnt();
      for (int k = 3; k >= 0; k--) begin
        for (int g = 0; g < GATES; g++) begin
          outer[g] = ov[g][k];
          inner[g] = iv[g][k];
        end
        repeat (k == 0 ? 4 : hold) tick();
      end
      cand = m_cnt + m_e - m_x;
      if (cand > CAPACITY)  begin m_cnt = CAPACITY; m_ovf = 1; end
      else if (cand < 0)    begin m_cnt = 0;        m_unf = 1; end
      else                        m_cnt = cand;
      chk("rnd_count", count, m_cnt);
      chk("rnd_full", full, m_cnt == CAPACITY);
      chk("rnd_empty", empty, m_cnt == 0);
      chk("rnd_ovf", ovf, m_ovf);
      chk("rnd_unf", unf, m_unf);
      chk("rnd_seq_err", seq_err, 0);
      for (int g = 0; g < GATES; g++) begin
        chk("rnd_enter_pulses", ent_cnt[g], exp_ent[g]);
        chk("rnd_exit_pulses", ext_cnt[g], exp_ext[g]);
      end
      if ($urandom_range(0, 7) == 0) begin
        pulse_clr();
        m_ovf = 0; m_unf = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
